// File: rtl/asynch_fifo_if.sv
`timescale 1ns/1ps
// Producer/consumer bundle for asynch_fifo. The count signal exists only when
// ASYNCH_FIFO_COUNT_EN is defined.
interface asynch_fifo_if #(
   parameter int data_width = 8,
   parameter int depth      = 8
);
   localparam int addr_width = $clog2(depth);

   logic                  w_en;
   logic [data_width-1:0] din;
   logic                  r_en;
   logic [data_width-1:0] dout;
   logic                  full;
   logic                  empty;
   logic                  overflow;
   logic                  underflow;
`ifdef ASYNCH_FIFO_COUNT_EN
   logic [addr_width:0]   count;

   modport master (output w_en, din, r_en,
                   input  dout, full, empty, overflow, underflow, count);
   modport slave  (input  w_en, din, r_en,
                   output dout, full, empty, overflow, underflow, count);
`else
   modport master (output w_en, din, r_en,
                   input  dout, full, empty, overflow, underflow);
   modport slave  (input  w_en, din, r_en,
                   output dout, full, empty, overflow, underflow);
`endif
endinterface

// File: rtl/asynch_fifo.sv
`timescale 1ns/1ps
// Single-clock FIFO with registered read data and sticky overflow/underflow.
// Define ASYNCH_FIFO_COUNT_EN to add the occupancy count output.
module asynch_fifo #(
   parameter int data_width = 8,
   parameter int depth      = 8
) (
   input logic          wclk,
   input logic          wrst,
   asynch_fifo_if.slave bus
);
   localparam int addr_width = $clog2(depth);
   localparam logic [addr_width:0] ptr_one = 1;

   // Handshake: a write is taken on a wclk edge when w_en=1 and full=0, a read
   // when r_en=1 and empty=0; a refused request only sets its sticky flag.
   logic [data_width-1:0] mem [depth];
   logic [addr_width:0]   wptr;
   logic [addr_width:0]   rptr;
   logic [data_width-1:0] dout_q;
   logic                  overflow_q;
   logic                  underflow_q;
   logic                  full;
   logic                  empty;
   logic                  wr_ok;
   logic                  rd_ok;

   // The pointer MSB is a wrap bit that tells full apart from empty.
   assign empty = (wptr == rptr);
   assign full  = (wptr[addr_width] != rptr[addr_width]) &&
                  (wptr[addr_width-1:0] == rptr[addr_width-1:0]);
   assign wr_ok = bus.w_en && !full;
   assign rd_ok = bus.r_en && !empty;

   // Storage is deliberately left out of reset.
   always_ff @(posedge wclk) begin
      if (wr_ok) mem[wptr[addr_width-1:0]] <= bus.din;
   end

   always_ff @(posedge wclk or negedge wrst) begin
      if (!wrst) begin
         wptr        <= '0;
         rptr        <= '0;
         dout_q      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_ok) wptr <= wptr + ptr_one;
         if (rd_ok) begin
            rptr   <= rptr + ptr_one;
            dout_q <= mem[rptr[addr_width-1:0]];
         end
         if (bus.w_en && full)  overflow_q  <= 1'b1;
         if (bus.r_en && empty) underflow_q <= 1'b1;
      end
   end

   assign bus.dout      = dout_q;
   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;

`ifdef ASYNCH_FIFO_COUNT_EN
   assign bus.count = wptr - rptr;
`endif
endmodule

// File: tb/tb_asynch_fifo.sv
`timescale 1ns/1ps
// Self-checking bench for asynch_fifo: directed plan followed by random traffic,
// checked against a queue-based reference model.
module tb_asynch_fifo;
   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic wclk;
   logic wrst;

   asynch_fifo_if #(.data_width(DW), .depth(DEPTH)) bus ();

   asynch_fifo #(.data_width(DW), .depth(DEPTH)) dut (
      .wclk (wclk),
      .wrst (wrst),
      .bus  (bus)
   );

   // clock / reset
   initial begin
      wclk = 1'b0;
      forever #5 wclk = ~wclk;
   end

   // reference model
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_dout;
   logic          exp_over;
   logic          exp_under;
   int            checks;
   int            errors;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".dout"},      32'(bus.dout),      32'(exp_dout));
      check({tag, ".full"},      32'(bus.full),      32'(exp_q.size() == DEPTH));
      check({tag, ".empty"},     32'(bus.empty),     32'(exp_q.size() == 0));
      check({tag, ".overflow"},  32'(bus.overflow),  32'(exp_over));
      check({tag, ".underflow"}, 32'(bus.underflow), 32'(exp_under));
`ifdef ASYNCH_FIFO_COUNT_EN
      check({tag, ".count"},     32'(bus.count),     32'(exp_q.size()));
`endif
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_dout  = '0;
      exp_over  = 1'b0;
      exp_under = 1'b0;
   endtask

   // driver: inputs change after a falling edge, outputs sampled at the next falling edge
   task automatic step(input string tag, input logic we, input logic re, input logic [DW-1:0] d);
      bit was_full;
      bit was_empty;
      bus.w_en  = we;
      bus.r_en  = re;
      bus.din   = d;
      was_full  = (exp_q.size() == DEPTH);
      was_empty = (exp_q.size() == 0);
      if (re && !was_empty) exp_dout = exp_q.pop_front();
      if (we && !was_full)  exp_q.push_back(d);
      if (we && was_full)   exp_over  = 1'b1;
      if (re && was_empty)  exp_under = 1'b1;
      @(posedge wclk);
      @(negedge wclk);
      bus.w_en = 1'b0;
      bus.r_en = 1'b0;
      check_all(tag);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      bus.w_en = 1'b0;
      bus.r_en = 1'b0;
      bus.din  = '0;
      model_reset();

      // reset held low for 10 ns
      wrst = 1'b0;
      #10;
      wrst = 1'b1;
      @(negedge wclk);
      check_all("reset");

      // fill 0x11..0x88, then a refused write
      for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, 8'(i * 8'h11));
      step("fill_over", 1'b1, 1'b0, 8'h99);

      // drain, then a refused read
      for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, 8'h00);
      step("drain_under", 1'b0, 1'b1, 8'h00);

      // wrap the pointers
      for (int i = 0; i < 5; i++) step("wrap_w5", 1'b1, 1'b0, 8'($urandom_range(0, 255)));
      for (int i = 0; i < 5; i++) step("wrap_r5", 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 8; i++) step("wrap_w8", 1'b1, 1'b0, 8'(8'hA0 + i));
      for (int i = 0; i < 8; i++) step("wrap_r8", 1'b0, 1'b1, 8'h00);

      // simultaneous read/write with 3 entries held
      for (int i = 0; i < 3; i++) step("sim_pre", 1'b1, 1'b0, 8'(8'h30 + i));
      for (int i = 0; i < 4; i++) step("sim_rw", 1'b1, 1'b1, 8'(8'h40 + i));

      // asynchronous reset between clock edges with 4 entries held
      step("pre_rst", 1'b1, 1'b0, 8'h55);
      #2;
      wrst = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      @(negedge wclk);
      check_all("rst_hold");
      wrst = 1'b1;

      // simultaneous from empty: write only, underflow set
      step("sim_empty", 1'b1, 1'b1, 8'h5A);
      step("first_after_rst", 1'b0, 1'b1, 8'h00);

      // full with simultaneous request: read only, overflow set
      for (int i = 0; i < 8; i++) step("refill", 1'b1, 1'b0, 8'(8'hC0 + i));
      step("sim_full", 1'b1, 1'b1, 8'hEE);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
